cpu_muldiv_issue: RTL and testbench
===================================

// Module: cpu_muldiv_issue
// PURPOSE
//  Execute-stage initiator for the MUL/DIV unit. Accepts one decoded RV32M instruction (valid/ready),
//  decodes funct3 into op selector and operand signedness, and drives the unit's request side.
//  Holds operands stable until the unit's done pulse, then presents the result on a writeback
//  valid/ready port. Supports pipeline flush and a watchdog timeout.
// PARAMETERS
//  p_timeout  64  EXEC cycles without done before abort; 0 disables the watchdog
// PORTS
//  i_clk         in   1   global clock
//  i_rst_n       in   1   synchronous active-low reset
//  i_req_valid   in   1   decoded M-instruction valid
//  o_req_ready   out  1   request accepted when valid&ready
//  i_funct3      in   3   RV32M funct3
//  i_rs1         in   32  operand A
//  i_rs2         in   32  operand B
//  i_rd          in   5   destination register
//  i_flush       in   1   kill in-flight op (branch/trap)
//  o_en_exec     out  1   MUL/DIV execute enable
//  o_sel_md_op   out  sel_md_op_e  op selector (pck_control)
//  o_opa_signed  out  1   operand A signed
//  o_opb_signed  out  1   operand B signed
//  o_op_a        out  32  latched operand A
//  o_op_b        out  32  latched operand B
//  i_md_out      in   32  MUL/DIV result
//  i_md_done     in   1   MUL/DIV done (result valid this cycle)
//  o_wb_valid    out  1   writeback valid
//  i_wb_ready    in   1   writeback accepted
//  o_wb_data     out  32  result
//  o_wb_rd       out  5   destination register
//  o_busy        out  1   state != IDLE (pipeline stall)
//  o_timeout     out  1   one-cycle pulse on watchdog abort
// BEHAVIOUR
//  Reset (i_rst_n=0 at posedge, highest priority): state IDLE, counter 0, latched regs 0.
//   While low: o_req_ready, o_en_exec, o_wb_valid, o_busy, o_timeout = 0;
//   o_sel_md_op = muldiv_none; o_op_a, o_op_b, o_wb_data = 0; o_wb_rd = 0.
//  funct3 decode (sel, A signed, B signed): 000 mull,1,1  001 mulh,1,1  010 mulh,1,0
//   011 mulh,0,0  100 div,1,1  101 div,0,0  110 rem,1,1  111 rem,0,0.
//  FSM IDLE -> EXEC -> WB -> IDLE.
//   IDLE: o_req_ready = ~i_flush. On accept latch funct3-decode, rs1, rs2, rd.
//     rd==0: op discarded, stay IDLE, never issued. Else -> EXEC, counter cleared.
//   EXEC: o_en_exec=1; sel/signed/op_a/op_b from latches, stable every EXEC cycle.
//     i_md_done: capture i_md_out -> o_wb_data, -> WB; o_en_exec low next cycle.
//     Counter increments each EXEC cycle without done. When count reaches p_timeout-1
//     (p_timeout!=0) and no done: o_timeout pulses next cycle, -> IDLE, no writeback.
//   WB: o_wb_valid=1; o_wb_data/o_wb_rd stable until i_wb_ready; then -> IDLE.
//  Outside EXEC: o_en_exec=0, o_sel_md_op=muldiv_none. i_md_done ignored outside EXEC.
//  Latency: accept at edge N; o_en_exec high in cycle N+1; done in cycle M -> o_wb_valid in M+1.
//   Minimum request-to-request spacing: 3 cycles (done in first EXEC cycle, wb_ready=1).
//  Priority per cycle: reset > i_flush > i_md_done > timeout.
//  i_flush: EXEC or WB -> IDLE next cycle, no writeback, no o_timeout; in IDLE blocks accept.
//  Unit sees en fall on flush/timeout and self-aborts; a late i_md_done is ignored.
//  o_busy = (state != IDLE); no new request is accepted while busy.
//  Divide-by-zero/overflow results come from the unit and are passed through unmodified.
// TESTING
//  MULHU (011) rs1=rs2=0xFFFFFFFF, rd=5, done after 3 cycles with 0xFFFFFFFE
//   -> sel=mulh, signed 0/0; o_wb_data=0xFFFFFFFE, o_wb_rd=5, valid the cycle after done.
//  DIV (100) 0x80000000 / 0xFFFFFFFF, model returns 0x80000000
//   -> signed 1/1, sel=div, o_wb_data=0x80000000.
//  Request rd=0 funct3=000 -> o_en_exec never high; o_req_ready=1 in the next cycle.
//  i_flush in 2nd EXEC cycle, then model done 2 cycles later
//   -> o_en_exec low next cycle, o_wb_valid never high, state IDLE.
//  i_wb_ready held low 5 cycles -> o_wb_valid/o_wb_data stable; o_req_ready=0; IDLE after ready.
//  p_timeout=8, model never done -> o_timeout 1-cycle pulse after 8th EXEC cycle; IDLE.
//   Reset asserted mid-EXEC -> all outputs 0 next cycle.

Source files
------------

// File: rtl/cpu_muldiv_issue.sv
// Execute-stage initiator for the RV32M MUL/DIV unit: decodes funct3, holds the operands
// steady while the unit runs, then hands the result to writeback.
package pck_control;
    typedef enum logic [2:0] {
        muldiv_none = 3'd0,
        muldiv_mull = 3'd1,
        muldiv_mulh = 3'd2,
        muldiv_div  = 3'd3,
        muldiv_rem  = 3'd4
    } sel_md_op_e;
endpackage

module cpu_muldiv_issue #(
    parameter int p_timeout = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [2:0]              i_funct3,
    input  logic [31:0]             i_rs1,
    input  logic [31:0]             i_rs2,
    input  logic [4:0]              i_rd,
    input  logic                    i_flush,
    output logic                    o_en_exec,
    output pck_control::sel_md_op_e o_sel_md_op,
    output logic                    o_opa_signed,
    output logic                    o_opb_signed,
    output logic [31:0]             o_op_a,
    output logic [31:0]             o_op_b,
    input  logic [31:0]             i_md_out,
    input  logic                    i_md_done,
    output logic                    o_wb_valid,
    input  logic                    i_wb_ready,
    output logic [31:0]             o_wb_data,
    output logic [4:0]              o_wb_rd,
    output logic                    o_busy,
    output logic                    o_timeout
);
    import pck_control::*;

    localparam int              cnt_w    = (p_timeout > 1) ? $clog2(p_timeout) : 1;
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'((p_timeout > 0) ? p_timeout - 1 : 0);
    localparam bit              wd_en    = (p_timeout != 0);

    typedef enum logic [1:0] {st_idle, st_exec, st_wb} state_e;

    state_e           state, state_nxt;
    logic [cnt_w-1:0] cnt;
    sel_md_op_e       dec_sel, lat_sel;
    logic             dec_a_signed, dec_b_signed;
    logic             lat_a_signed, lat_b_signed;
    logic [31:0]      lat_op_a, lat_op_b, wb_data;
    logic [4:0]       lat_rd;
    logic             timeout_q;
    logic             accept, exec_live, exec_done, wd_hit;

    assign accept    = (state == st_idle) && i_req_valid && !i_flush;
    // A flush outranks both done and the watchdog in the same cycle.
    assign exec_live = (state == st_exec) && !i_flush;
    assign exec_done = exec_live && i_md_done;
    assign wd_hit    = wd_en && exec_live && !i_md_done && (cnt == cnt_last);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        dec_sel      = muldiv_none;
        dec_a_signed = 1'b0;
        dec_b_signed = 1'b0;
        case (i_funct3)
            3'b000: begin dec_sel = muldiv_mull; dec_a_signed = 1'b1; dec_b_signed = 1'b1; end
            3'b001: begin dec_sel = muldiv_mulh; dec_a_signed = 1'b1; dec_b_signed = 1'b1; end
            3'b010: begin dec_sel = muldiv_mulh; dec_a_signed = 1'b1; end
            3'b011: dec_sel = muldiv_mulh;
            3'b100: begin dec_sel = muldiv_div;  dec_a_signed = 1'b1; dec_b_signed = 1'b1; end
            3'b101: dec_sel = muldiv_div;
            3'b110: begin dec_sel = muldiv_rem;  dec_a_signed = 1'b1; dec_b_signed = 1'b1; end
            default: dec_sel = muldiv_rem;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!i_rst_n) state <= st_idle;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            st_idle: if (accept && (i_rd != 5'd0)) state_nxt = st_exec;
            st_exec: begin
                if (i_flush)        state_nxt = st_idle;
                else if (i_md_done) state_nxt = st_wb;
                else if (wd_hit)    state_nxt = st_idle;
            end
            st_wb:   if (i_flush || i_wb_ready) state_nxt = st_idle;
            default: state_nxt = st_idle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt          <= '0;
            lat_sel      <= muldiv_none;
            lat_a_signed <= 1'b0;
            lat_b_signed <= 1'b0;
            lat_op_a     <= '0;
            lat_op_b     <= '0;
            lat_rd       <= '0;
            wb_data      <= '0;
            timeout_q    <= 1'b0;
        end else begin
            timeout_q <= wd_hit;
            if (accept) begin
                lat_sel      <= dec_sel;
                lat_a_signed <= dec_a_signed;
                lat_b_signed <= dec_b_signed;
                lat_op_a     <= i_rs1;
                lat_op_b     <= i_rs2;
                lat_rd       <= i_rd;
                cnt          <= '0;
            end else if (exec_live && !i_md_done) begin
                cnt <= cnt + cnt_w'(1);
            end
            if (exec_done) wb_data <= i_md_out;
        end
    end

    // Reset is synchronous, so outputs are also gated by i_rst_n to read zero while it is held low.
    always_comb begin
        o_req_ready  = 1'b0;
        o_en_exec    = 1'b0;
        o_sel_md_op  = muldiv_none;
        o_opa_signed = 1'b0;
        o_opb_signed = 1'b0;
        o_op_a       = '0;
        o_op_b       = '0;
        o_wb_valid   = 1'b0;
        o_wb_data    = '0;
        o_wb_rd      = '0;
        o_busy       = 1'b0;
        o_timeout    = 1'b0;
        if (i_rst_n) begin
            o_req_ready  = (state == st_idle) && !i_flush;
            o_en_exec    = (state == st_exec);
            o_sel_md_op  = (state == st_exec) ? lat_sel : muldiv_none;
            o_opa_signed = lat_a_signed;
            o_opb_signed = lat_b_signed;
            o_op_a       = lat_op_a;
            o_op_b       = lat_op_b;
            o_wb_valid   = (state == st_wb);
            o_wb_data    = wb_data;
            o_wb_rd      = lat_rd;
            o_busy       = (state != st_idle);
            o_timeout    = timeout_q;
        end
    end

endmodule

// File: tb/tb_cpu_muldiv_issue.sv
// Bench for cpu_muldiv_issue: plays the MUL/DIV unit, drives directed and random instructions,
// and scoreboards writebacks against an arithmetic RV32M reference.
module tb_cpu_muldiv_issue;
    import pck_control::*;

    localparam int p_to = 8;

    logic        i_clk, i_rst_n;
    logic        i_req_valid, o_req_ready;
    logic [2:0]  i_funct3;
    logic [31:0] i_rs1, i_rs2;
    logic [4:0]  i_rd;
    logic        i_flush, o_en_exec;
    sel_md_op_e  o_sel_md_op;
    logic        o_opa_signed, o_opb_signed;
    logic [31:0] o_op_a, o_op_b, i_md_out;
    logic        i_md_done, o_wb_valid, i_wb_ready;
    logic [31:0] o_wb_data;
    logic [4:0]  o_wb_rd;
    logic        o_busy, o_timeout;

    cpu_muldiv_issue #(.p_timeout(p_to)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_funct3(i_funct3), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
        .i_flush(i_flush), .o_en_exec(o_en_exec), .o_sel_md_op(o_sel_md_op),
        .o_opa_signed(o_opa_signed), .o_opb_signed(o_opb_signed),
        .o_op_a(o_op_a), .o_op_b(o_op_b), .i_md_out(i_md_out), .i_md_done(i_md_done),
        .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready),
        .o_wb_data(o_wb_data), .o_wb_rd(o_wb_rd),
        .o_busy(o_busy), .o_timeout(o_timeout)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
    } wb_t;

    typedef struct packed {
        sel_md_op_e sel;
        logic       a_signed;
        logic       b_signed;
    } dec_t;

    wb_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // RV32M semantics, including the divide-by-zero and overflow results the unit produces.
    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub;
        logic [63:0] ua, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        ua = {32'b0, a};
        case (f3)
            3'b000: begin p = sa * sb; return p[31:0];  end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic dec_t exp_decode(input logic [2:0] f3);
        dec_t d;
        d.sel      = (f3 == 3'b000) ? muldiv_mull :
                     (f3[2] == 1'b0) ? muldiv_mulh :
                     (f3[1] == 1'b0) ? muldiv_div : muldiv_rem;
        d.a_signed = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
        d.b_signed = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
        return d;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, o_req_ready, 0);
        check({tag, "_en_exec"},   o_en_exec,   0);
        check({tag, "_sel"},       o_sel_md_op, muldiv_none);
        check({tag, "_op_a"},      o_op_a,      0);
        check({tag, "_op_b"},      o_op_b,      0);
        check({tag, "_wb_valid"},  o_wb_valid,  0);
        check({tag, "_wb_data"},   o_wb_data,   0);
        check({tag, "_wb_rd"},     o_wb_rd,     0);
        check({tag, "_busy"},      o_busy,      0);
        check({tag, "_timeout"},   o_timeout,   0);
    endtask

    // Issue one instruction and act as the unit. done_at/flush_at/rst_at name the EXEC cycle
    // (1-based) of that event, 0 meaning never; stall is the number of cycles wb_ready stays low.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int done_at, input int flush_at,
                         input int stall, input int rst_at);
        logic [31:0] res;
        dec_t        d;
        bit          fin;
        res = ref_md(f3, a, b);
        d   = exp_decode(f3);
        step();
        i_req_valid = 1'b1;
        i_funct3    = f3;
        i_rs1       = a;
        i_rs2       = b;
        i_rd        = rd;
        @(negedge i_clk);
        check("req_ready_idle", o_req_ready, 1);
        step();
        i_req_valid = 1'b0;
        i_funct3    = 3'($urandom);
        i_rs1       = $urandom;
        i_rs2       = $urandom;
        i_rd        = 5'($urandom);
        if (rd == 5'd0) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge i_clk);
                check("rd0_en_exec", o_en_exec, 0);
                check("rd0_req_ready", o_req_ready, 1);
                step();
            end
            return;
        end
        fin = 1'b0;
        for (int k = 1; k <= p_to + 1 && !fin; k++) begin
            i_md_done = (k == done_at);
            i_md_out  = (k == done_at) ? res : $urandom;
            i_flush   = (k == flush_at);
            @(negedge i_clk);
            check("exec_en",       o_en_exec,    1);
            check("exec_busy",     o_busy,       1);
            check("exec_sel",      o_sel_md_op,  d.sel);
            check("exec_a_signed", o_opa_signed, d.a_signed);
            check("exec_b_signed", o_opb_signed, d.b_signed);
            check("exec_op_a",     o_op_a,       a);
            check("exec_op_b",     o_op_b,       b);
            check("exec_timeout",  o_timeout,    0);
            check("exec_wb_valid", o_wb_valid,   0);
            if (k == rst_at) begin
                i_md_done = 1'b0;
                i_rst_n   = 1'b0;
            end
            if (k == done_at && k != flush_at && k != rst_at) begin
                sb_q.push_back('{data: res, rd: rd});
                if (stall > 0) i_wb_ready = 1'b0;
            end
            step();
            i_md_done = 1'b0;
            i_flush   = 1'b0;
            i_md_out  = $urandom;
            if (k == rst_at) begin
                @(negedge i_clk);
                check_zero("rst_mid");
                step();
                i_rst_n = 1'b1;
                @(negedge i_clk);
                check("rst_mid_busy_after", o_busy, 0);
                check("rst_mid_op_a_cleared", o_op_a, 0);
                fin = 1'b1;
            end else if (k == flush_at) begin
                @(negedge i_clk);
                check("flush_en_exec", o_en_exec, 0);
                check("flush_wb_valid", o_wb_valid, 0);
                check("flush_busy", o_busy, 0);
                step();
                i_md_done = 1'b1;
                i_md_out  = res;
                @(negedge i_clk);
                check("late_done_wb_valid", o_wb_valid, 0);
                step();
                i_md_done = 1'b0;
                @(negedge i_clk);
                check("late_done_wb_valid_next", o_wb_valid, 0);
                check("late_done_busy", o_busy, 0);
                check("late_done_timeout", o_timeout, 0);
                fin = 1'b1;
            end else if (k == done_at) begin
                for (int s = 0; s < stall; s++) begin
                    @(negedge i_clk);
                    check("stall_wb_valid", o_wb_valid, 1);
                    check("stall_wb_data", o_wb_data, res);
                    check("stall_wb_rd", o_wb_rd, rd);
                    check("stall_req_ready", o_req_ready, 0);
                    check("stall_en_exec", o_en_exec, 0);
                    step();
                end
                i_wb_ready = 1'b1;
                @(negedge i_clk);
                check("wb_valid_after_done", o_wb_valid, 1);
                check("wb_en_exec", o_en_exec, 0);
                check("wb_sel_none", o_sel_md_op, muldiv_none);
                step();
                @(negedge i_clk);
                check("wb_then_idle", o_busy, 0);
                fin = 1'b1;
            end else if (k == p_to) begin
                @(negedge i_clk);
                check("timeout_pulse", o_timeout, 1);
                check("timeout_busy", o_busy, 0);
                check("timeout_wb_valid", o_wb_valid, 0);
                check("timeout_en_exec", o_en_exec, 0);
                step();
                @(negedge i_clk);
                check("timeout_one_cycle", o_timeout, 0);
                fin = 1'b1;
            end
        end
        if (!fin) begin
            n_checks++;
            n_errors++;
            $display("FAIL issue_bound: op rd=%0d did not resolve within %0d EXEC cycles", rd, p_to + 1);
        end
    endtask

    // Scoreboard monitor: every accepted writeback must match the oldest expected result.
    always @(negedge i_clk) begin
        if (i_rst_n && o_wb_valid && i_wb_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL wb_unexpected: got data %h rd %0d, expected no writeback", o_wb_data, o_wb_rd);
            end else begin
                wb_t e;
                e = sb_q.pop_front();
                check("sb_wb_data", o_wb_data, e.data);
                check("sb_wb_rd", o_wb_rd, e.rd);
            end
        end
    end

    initial begin
        i_rst_n     = 1'b0;
        i_req_valid = 1'b1;
        i_funct3    = 3'b000;
        i_rs1       = 32'h1234_5678;
        i_rs2       = 32'h9ABC_DEF0;
        i_rd        = 5'd1;
        i_flush     = 1'b0;
        i_md_out    = 32'hDEAD_BEEF;
        i_md_done   = 1'b1;
        i_wb_ready  = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check_zero("reset");
        step();
        i_rst_n     = 1'b1;
        i_req_valid = 1'b0;
        i_md_done   = 1'b0;

        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 3, 0, 0, 0);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1, 0, 0, 0);
        issue(3'b000, 32'd3, 32'd4, 5'd0, 1, 0, 0, 0);
        issue(3'b110, $urandom, $urandom, 5'd9, 0, 2, 0, 0);
        issue(3'b001, $urandom, $urandom, 5'd12, 2, 0, 5, 0);
        issue(3'b101, $urandom, $urandom, 5'd3, 0, 0, 0, 0);
        issue(3'b111, $urandom, $urandom, 5'd4, 0, 0, 0, 3);

        // A flush while idle must block acceptance.
        step();
        i_req_valid = 1'b1;
        i_flush     = 1'b1;
        i_rd        = 5'd6;
        @(negedge i_clk);
        check("flush_idle_ready", o_req_ready, 0);
        step();
        i_req_valid = 1'b0;
        i_flush     = 1'b0;
        @(negedge i_clk);
        check("flush_idle_busy", o_busy, 0);
        check("flush_idle_en", o_en_exec, 0);

        for (int n = 0; n < 40; n++) begin
            logic [2:0] f3;
            logic [4:0] rd;
            int done_at, flush_at;
            f3       = 3'($urandom);
            rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            done_at  = $urandom_range(1, 6);
            flush_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, done_at) : 0;
            issue(f3, pick_operand(), pick_operand(), rd, done_at, flush_at, $urandom_range(0, 3), 0);
            if ($urandom_range(0, 1) == 1) step();
        end

        repeat (3) step();
        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
